// File: rtl/pulse_width_classifier_if.sv
// Classified-event stream: valid/ready handshake carrying channel, class and width.
interface pulse_width_classifier_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic             ev_valid;
    logic             ev_ready;
    logic [CH_W-1:0]  ev_ch;
    logic [1:0]       ev_class;
    logic [CNT_W-1:0] ev_width;

    modport master (output ev_valid, ev_ch, ev_class, ev_width, input  ev_ready);
    modport slave  (input  ev_valid, ev_ch, ev_class, ev_width, output ev_ready);
endinterface

// File: rtl/pulse_width_classifier.sv
// Multi-channel pulse-width classifier: synchronises each input, measures high
// pulses in clock cycles, classifies them and streams events round-robin.
module pulse_width_classifier #(
    parameter int CH        = 4,
    parameter int CNT_W     = 8,
    parameter int SHORT_MIN = 4,
    parameter int LONG_MIN  = 12,
    parameter int TIMEOUT   = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH-1:0]            in,
    pulse_width_classifier_if.master ev,
    output logic [CH-1:0]            overrun
);
    localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CNT_W-1:0] SHORT_W = CNT_W'(SHORT_MIN);
    localparam logic [CNT_W-1:0] LONG_W  = CNT_W'(LONG_MIN);
    localparam logic [CNT_W-1:0] TMO_W   = CNT_W'(TIMEOUT);
    localparam logic [1:0] CLS_NONE  = 2'b00;
    localparam logic [1:0] CLS_SHORT = 2'b01;
    localparam logic [1:0] CLS_LONG  = 2'b10;
    localparam logic [1:0] CLS_TMO   = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, MEAS = 2'd1, STUCK = 2'd2} state_t;

    // Width-to-class mapping for a completed (non-stuck) pulse.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] w);
        if (w < SHORT_W)     return CLS_NONE;
        else if (w < LONG_W) return CLS_SHORT;
        else                 return CLS_LONG;
    endfunction

    logic [CH-1:0]    s1, s2, s3, rise, fall;
    state_t           state    [CH];
    state_t           state_nx [CH];
    logic [CNT_W-1:0] cnt      [CH];
    logic [CNT_W-1:0] cnt_nx   [CH];
    logic [CH-1:0]    tmo, tmo_nx;
    logic [CH-1:0]    new_ev;
    logic [1:0]       new_cls  [CH];
    logic [CNT_W-1:0] new_wid  [CH];

    logic [CH-1:0]    slot_pend;
    logic [1:0]       slot_cls [CH];
    logic [CNT_W-1:0] slot_wid [CH];

    logic [CH_W-1:0]  rr_ptr, gnt_idx, pos_idx;
    logic             gnt_any, load;
    logic [CH-1:0]    take;
    int               pos;

    logic             out_valid;
    logic [CH_W-1:0]  out_ch;
    logic [1:0]       out_cls;
    logic [CNT_W-1:0] out_wid;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    assign load = !out_valid || ev.ev_ready;

    assign ev.ev_valid = out_valid;
    assign ev.ev_ch    = out_ch;
    assign ev.ev_class = out_cls;
    assign ev.ev_width = out_wid;

    // Three-flop synchroniser per channel; s3 is kept only for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Per-channel measurement FSM: next state, counter and event generation.
    // The timeout event is raised one cycle after entering STUCK via tmo.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            state_nx[c] = state[c];
            cnt_nx[c]   = cnt[c];
            tmo_nx[c]   = 1'b0;
            new_ev[c]   = tmo[c];
            new_cls[c]  = CLS_TMO;
            new_wid[c]  = TMO_W;
            case (state[c])
                IDLE: begin
                    if (rise[c]) begin
                        state_nx[c] = MEAS;
                        cnt_nx[c]   = CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (fall[c]) begin
                        state_nx[c] = IDLE;
                        new_cls[c]  = classify(cnt[c]);
                        new_wid[c]  = cnt[c];
                        new_ev[c]   = (classify(cnt[c]) != CLS_NONE);
                    end else begin
                        cnt_nx[c] = cnt[c] + 1'b1;
                        if (cnt[c] + 1'b1 == TMO_W) begin
                            state_nx[c] = STUCK;
                            tmo_nx[c]   = 1'b1;
                        end
                    end
                end
                STUCK: begin
                    if (fall[c]) state_nx[c] = IDLE;
                end
                default: state_nx[c] = IDLE;
            endcase
        end
    end

    // FSM state, counter and deferred-timeout flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                state[c] <= IDLE;
                cnt[c]   <= '0;
            end
            tmo <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                state[c] <= state_nx[c];
                cnt[c]   <= cnt_nx[c];
            end
            tmo <= tmo_nx;
        end
    end

    // Round-robin search for the first pending slot at or after rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        pos     = 0;
        pos_idx = '0;
        take    = '0;
        for (int i = 0; i < CH; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= CH) pos = pos - CH;
            pos_idx = CH_W'(pos);
            if (!gnt_any && slot_pend[pos_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = pos_idx;
            end
        end
        if (load && gnt_any) take[gnt_idx] = 1'b1;
    end

    // One-entry slot per channel; a slot being drained this edge may be refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_pend <= '0;
            overrun   <= '0;
            for (int c = 0; c < CH; c++) begin
                slot_cls[c] <= '0;
                slot_wid[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (new_ev[c]) begin
                    if (!slot_pend[c] || take[c]) begin
                        slot_pend[c] <= 1'b1;
                        slot_cls[c]  <= new_cls[c];
                        slot_wid[c]  <= new_wid[c];
                    end else begin
                        overrun[c] <= 1'b1;
                    end
                end else if (take[c]) begin
                    slot_pend[c] <= 1'b0;
                end
            end
        end
    end

    // Output register: reloads whenever empty or being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_cls   <= '0;
            out_wid   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_ch    <= gnt_idx;
                out_cls   <= slot_cls[gnt_idx];
                out_wid   <= slot_wid[gnt_idx];
                rr_ptr    <= (int'(gnt_idx) == CH - 1) ? '0 : gnt_idx + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
